// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the TX feeder state encoding.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LAUNCH    = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_GAP       = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      LAUNCH    = ST_LAUNCH,
      WAIT_DONE = ST_WAIT_DONE,
      GAP       = ST_GAP
   } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter and registered flags.
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_data,
   input  logic                     i_flush,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             r_full;
   logic             r_empty;

   logic             w_push_ok;
   logic             w_pop_ok;
   logic [LVL_W-1:0] w_level_nxt;

   // Overflow and underflow requests are silently refused here.
   assign w_push_ok = i_push && !r_full;
   assign w_pop_ok  = i_pop && !r_empty;

   // Occupancy update for the four push/pop combinations.
   always_comb begin
      w_level_nxt = r_level;
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_level_nxt = r_level + LVL_W'(1);
         2'b01:   w_level_nxt = r_level - LVL_W'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // Pointers, level and flags; flush outranks any same-cycle push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LVL_W'(DEPTH));
         r_empty <= (w_level_nxt == LVL_W'(0));
      end
   end

   // Storage array; contents are only meaningful below the level count.
   always_ff @(posedge clk) begin
      if (w_push_ok && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_level    = r_level;
   assign o_full     = r_full;
   assign o_empty    = r_empty;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and feeds them to uart_tx one frame at a time,
// pacing launches on tx_done plus an optional idle gap.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int GAP_CLKS = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_valid,
   input  logic [UART_DATA_W-1:0]   wr_data,
   output logic                     wr_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     empty,
   output logic                     full,
   output logic                     tx_start,
   output logic [UART_DATA_W-1:0]   tx_data,
   input  logic                     tx_done,
   input  logic                     tx_active
);

   localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CLKS > 0) ? GAP_W'(GAP_CLKS - 1) : '0;

   feeder_state_t          r_state;
   feeder_state_t          w_state_nxt;
   logic [GAP_W-1:0]       r_gap_cnt;
   logic [GAP_W-1:0]       w_gap_nxt;
   logic                   r_tx_start;
   logic [UART_DATA_W-1:0] r_tx_data;

   logic                   w_launch;
   logic                   w_empty;
   logic                   w_full;
   logic [UART_DATA_W-1:0] w_head;

   uart_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (UART_DATA_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (wr_valid),
      .i_push_data (wr_data),
      .i_pop       (w_launch),
      .o_pop_data  (w_head),
      .i_flush     (flush),
      .o_level     (level),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   // The pop and the launch are the same event, so the head lands in tx_data.
   assign w_launch = (r_state == IDLE) && !w_empty && !tx_active;

   // Next-state and gap-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      case (r_state)
         IDLE: begin
            if (w_launch) begin
               w_state_nxt = LAUNCH;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LAUNCH: begin
            w_state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               if (GAP_CLKS == 0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = GAP;
                  w_gap_nxt   = GAP_LOAD;
               end
            end else begin
               w_state_nxt = WAIT_DONE;
            end
         end
         GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_gap_nxt = r_gap_cnt - GAP_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gap_nxt   = '0;
         end
      endcase
   end

   // State, gap counter and the registered transmitter command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gap_cnt  <= '0;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_gap_cnt  <= w_gap_nxt;
         r_tx_start <= w_launch;
         if (w_launch) begin
            r_tx_data <= w_head;
         end
      end
   end

   assign wr_ready = !w_full;
   assign empty    = w_empty;
   assign full     = w_full;
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;

endmodule
